// File: rtl/seg7_if.sv
// Display-side bundle for seg7_mux_driver: shadow-load inputs plus the
// multiplexed segment/anode pin outputs.
interface seg7_if #(
   parameter int NUM_DIGITS = 4,
   parameter int IDX_W      = $clog2(NUM_DIGITS)
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    lz_suppress;
   logic                    load;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic [IDX_W-1:0]        digit_idx;

   modport master (
      output value, dp_in, blank_in, lz_suppress, load,
      input  seg, dp, an, digit_idx
   );

   modport slave (
      input  value, dp_in, blank_in, lz_suppress, load,
      output seg, dp, an, digit_idx
   );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadowed hex value, per-digit
// dp/blank, leading-zero suppression and a dark guard cycle at every slot start.

// One lane per digit: hex decode plus the leading-zero chain link.
module seg7_digit_lane (
   input  logic [3:0] nib,
   input  logic       zero_above,
   output logic       zero_here,
   output logic [6:0] seg
);
   assign zero_here = zero_above & (nib == 4'h0);

   // Active-low {a,b,c,d,e,f,g}
   always_comb begin
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0001100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

module seg7_mux_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
   input  logic  clk,
   input  logic  rst_n,
   seg7_if.slave bus
);
   localparam int               CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] val_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;
   logic                    lz_sh;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [IDX_W-1:0]      idx_q;

   logic [NUM_DIGITS:0]             zchain;
   logic [NUM_DIGITS-1:0]           lane_zero;
   logic [NUM_DIGITS-1:0][6:0]      lane_seg;

   // zchain[i] is set when nibbles NUM_DIGITS-1 down to i are all zero
   assign zchain[NUM_DIGITS] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
      seg7_digit_lane u_lane (
         .nib        (val_sh[4*i +: 4]),
         .zero_above (zchain[i+1]),
         .zero_here  (zchain[i]),
         .seg        (lane_seg[i])
      );
   end

   assign lane_zero = zchain[NUM_DIGITS-1:0];

   // cnt==0 is the anti-ghosting guard: everything dark while anodes switch
   always_comb begin
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      an_d  = '1;
      if (cnt != '0) begin
         an_d[idx] = 1'b0;
         if (!blank_sh[idx]) begin
            dp_d = ~dp_sh[idx];
            if (!(lz_sh && (idx != '0) && lane_zero[idx]))
               seg_d = lane_seg[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_sh   <= '0;
         dp_sh    <= '0;
         blank_sh <= '0;
         lz_sh    <= 1'b0;
         cnt      <= '0;
         idx      <= '0;
         seg_q    <= 7'b1111111;
         dp_q     <= 1'b1;
         an_q     <= '1;
         idx_q    <= '0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         if (bus.load) begin
            val_sh   <= bus.value;
            dp_sh    <= bus.dp_in;
            blank_sh <= bus.blank_in;
            lz_sh    <= bus.lz_suppress;
         end

         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
         idx_q <= idx;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.an        = an_q;
   assign bus.digit_idx = idx_q;
endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomized bench for seg7_mux_driver: a time-based reference model predicts
// every output cycle from elapsed cycles since reset and the loaded shadow state.
module tb_seg7_mux_driver;
   localparam int ND = 4;
   localparam int RD = 4;

   localparam logic [6:0] DEC [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_if #(.NUM_DIGITS(ND)) bus ();

   seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // model: cycles elapsed since reset plus shadow contents
   int          t = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_dp = '0, m_blank = '0;
   logic        m_lz = 1'b0;

   // current input drive
   logic [15:0] iv = '0;
   logic [3:0]  idp = '0, ibl = '0;
   logic        ilz = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic ld);
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_an;
      logic [1:0] e_idx;
      logic [3:0] nib;
      int pos, dig;
      @(negedge clk);
      rst_n           = r;
      bus.load        = ld;
      bus.value       = iv;
      bus.dp_in       = idp;
      bus.blank_in    = ibl;
      bus.lz_suppress = ilz;
      @(posedge clk);
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
      e_an  = 4'b1111;
      e_idx = 2'd0;
      if (r) begin
         pos   = t % RD;
         dig   = (t / RD) % ND;
         e_idx = dig[1:0];
         if (pos != 0) begin
            e_an = ~(4'b0001 << dig);
            if (!m_blank[dig]) begin
               e_dp = ~m_dp[dig];
               nib  = 4'((m_val >> (4*dig)) & 16'hF);
               if (!(m_lz && dig != 0 && (m_val >> (4*dig)) == 0))
                  e_seg = DEC[nib];
            end
         end
         t++;
         if (ld) begin
            m_val = iv; m_dp = idp; m_blank = ibl; m_lz = ilz;
         end
      end else begin
         t = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
      end
      #1;
      chk("an", 32'(bus.an), 32'(e_an));
      chk("seg", 32'(bus.seg), 32'(e_seg));
      chk("dp", 32'(bus.dp), 32'(e_dp));
      chk("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
      chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
   endtask

   function automatic logic at_slot(input int d, input int p);
      return ((t % RD) == p) && (((t / RD) % ND) == d);
   endfunction

   initial begin
      bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
      bus.blank_in = '0; bus.lz_suppress = 1'b0;

      repeat (2) step(1'b0, 1'b0);

      iv = 16'h12AF;
      step(1'b1, 1'b1);
      repeat (19) step(1'b1, 1'b0);

      iv = 16'h0050; ilz = 1'b1;
      step(1'b1, 1'b1);
      repeat (16) step(1'b1, 1'b0);
      iv = 16'h0000;
      step(1'b1, 1'b1);
      repeat (16) step(1'b1, 1'b0);

      iv = 16'h8888; idp = 4'b0100; ibl = 4'b0001; ilz = 1'b0;
      step(1'b1, 1'b1);
      repeat (16) step(1'b1, 1'b0);

      // reload mid-way through digit 1's active cycles
      iv = 16'h3333; idp = '0; ibl = '0;
      step(1'b1, 1'b1);
      for (int n = 0; n < 64 && !at_slot(1, 2); n++) step(1'b1, 1'b0);
      chk("seek_d1", 32'(at_slot(1, 2)), 32'd1);
      iv = 16'h00C0;
      step(1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0);

      // one-edge reset during digit 2's active cycles
      for (int n = 0; n < 64 && !at_slot(2, 2); n++) step(1'b1, 1'b0);
      chk("seek_d2", 32'(at_slot(2, 2)), 32'd1);
      step(1'b0, 1'b1);
      repeat (8) step(1'b1, 1'b0);

      for (int k = 0; k < 16; k++) begin
         iv = 16'(k);
         step(1'b1, 1'b1);
         repeat (ND*RD - 1) step(1'b1, 1'b0);
      end

      repeat (600) begin
         iv  = 16'($urandom) >> $urandom_range(0, 16);
         idp = 4'($urandom);
         ibl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         ilz = 1'($urandom);
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
